// File: rtl/match_pkg.sv
// Shared types and default sizing for the match window counter.
// FSM encodings are fixed so they stay stable across builds.
package match_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    COUNT  = 2'b01,
    REPORT = 2'b10
  } state_e;

  localparam int DEF_WIN_LEN = 16;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_THRESH  = 4;

endpackage

// File: rtl/match_window_counter_sat_counter.sv
// Saturating up-counter: clr has priority over inc; holds at all-ones instead of wrapping.
// One cycle from inc to value; synchronous active-high reset.
module sat_counter
  import match_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != {CNT_W{1'b1}})) begin
      value_d = value_q + 1'b1;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/match_window_counter.sv
// Counts match flags over WIN_LEN-sample windows and reports the total with a one-cycle strobe.
// Optional sticky threshold alarm is built only when MATCH_WINDOW_ALARM_EN is defined.
module match_window_counter
  import match_pkg::*;
#(
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int THRESH  = DEF_THRESH
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic             match,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             cnt_valid,
  output logic             alarm
);

  localparam logic [7:0] WIN_LAST = 8'(WIN_LEN - 1);

  state_e           state_q;
  state_e           state_d;
  logic [7:0]       win_q;
  logic [7:0]       win_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             acc_clr;
  logic             acc_inc;
  logic [CNT_W-1:0] acc;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_acc (
    .ck   (ck),
    .rst  (rst),
    .clr  (acc_clr),
    .inc  (acc_inc),
    .value(acc)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    count_d = count_q;
    acc_clr = 1'b0;
    acc_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COUNT;
          win_d   = '0;
          acc_clr = 1'b1;
        end
      end
      COUNT: begin
        acc_inc = match;
        win_d   = win_q + 8'd1;
        if (win_q == WIN_LAST) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        // acc already holds the final sample taken on the edge into REPORT
        count_d = acc;
        if (start) begin
          state_d = COUNT;
          win_d   = '0;
          acc_clr = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      count_q <= count_d;
    end
  end

  assign busy      = (state_q == COUNT);
  assign cnt_valid = (state_q == REPORT);
  assign count     = cnt_valid ? acc : count_q;

`ifdef MATCH_WINDOW_ALARM_EN
  logic alarm_q;
  logic alarm_d;
  logic thresh_hit;
  logic start_acc;

  assign start_acc  = start && (state_q != COUNT);
  assign thresh_hit = (state_q == REPORT) && (int'(acc) >= THRESH);

  always_comb begin
    alarm_d = alarm_q | thresh_hit;
    if (start_acc) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q | thresh_hit;
`else
  // threshold only matters when the alarm is built in
  localparam int thresh_unused = THRESH;
  assign alarm = 1'b0;
`endif

endmodule

// File: doc/match_window_counter.md
MATCH_WINDOW_COUNTER -- requirements
Module: match_window_counter

Interface
REQ-001 SHALL have parameter WIN_LEN, default 16, giving the number of match samples per window (2..255).
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the match count.
REQ-003 SHALL have parameter THRESH, default 4, giving the alarm threshold in matches per window.
REQ-004 SHALL have port ck, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1, request to open a counting window.
REQ-007 SHALL have port match, input, 1, per-cycle match flag driven by the upstream sequence detector's dout.
REQ-008 SHALL have port busy, output, 1, high while a window is open.
REQ-009 SHALL have port count, output, CNT_W, the last completed window's match total.
REQ-010 SHALL have port cnt_valid, output, 1, one-cycle strobe marking a new count.
REQ-011 SHALL have port alarm, output, 1, sticky flag for threshold exceeded (see Configuration).

Function
REQ-012 SHALL implement an FSM with states IDLE, COUNT and REPORT.
REQ-013 IDLE: SHALL move to COUNT when start=1, clearing the window counter and the accumulator.
REQ-014 COUNT: SHALL sample match each cycle and add 1 to the accumulator when match=1.
- The accumulator SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-015 COUNT: SHALL move to REPORT after exactly WIN_LEN sampled cycles.
REQ-016 Latency: start seen at edge t SHALL cause samples at edges t+1..t+WIN_LEN, with cnt_valid=1 and count updated during the cycle after edge t+WIN_LEN.
REQ-017 REPORT: SHALL last one cycle, load count from the accumulator and assert cnt_valid; the accumulator load SHALL include any match sampled on the last COUNT cycle.
REQ-018 REPORT: SHALL go to COUNT when start=1 (back-to-back window, no idle gap) and to IDLE otherwise.
REQ-019 start SHALL be ignored in COUNT; an open window is never restarted or extended.
REQ-020 match SHALL be ignored in IDLE and REPORT.
REQ-021 busy SHALL be 1 only in COUNT.
REQ-022 count SHALL hold its value between REPORT cycles.
REQ-023 cnt_valid SHALL be 0 in every state other than REPORT.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE and clear the accumulator and window counter.
- Outputs after reset: busy=0, count=0, cnt_valid=0, alarm=0.
REQ-025 rst SHALL take priority over start, and an in-progress window SHALL be discarded without a cnt_valid strobe.

Configuration
REQ-026 Macro MATCH_WINDOW_ALARM_EN defined:
- In REPORT, alarm SHALL set when the loaded count >= THRESH.
- alarm SHALL stay set until rst or until the next accepted start clears it.
REQ-027 Macro MATCH_WINDOW_ALARM_EN undefined: the alarm port SHALL remain and be tied to 0, with no comparator logic synthesised.

Structure
REQ-028 FSM state encodings (IDLE=2'b00, COUNT=2'b01, REPORT=2'b10) and the default WIN_LEN/CNT_W/THRESH SHALL live in the shared package match_pkg.
REQ-029 The saturating accumulator SHALL be a sub-module sat_counter (CNT_W wide, inputs clr/inc, output value); everything else SHALL be flat.

Verification
REQ-030 Reset: rst held for 2 cycles mid-window (after 5 samples) -> busy=0, count=0, cnt_valid=0, alarm=0, and no strobe afterwards.
REQ-031 Basic window: start for 1 cycle, then match=1 on 3 of 16 cycles -> cnt_valid exactly 17 cycles after start, count=3, alarm=0.
REQ-032 Threshold: 4 matches in a window with MATCH_WINDOW_ALARM_EN -> count=4, alarm=1, cleared on the next start; the same stimulus without the macro -> alarm=0.
REQ-033 Back-to-back: start high continuously, match=1 every cycle -> cnt_valid every 17 cycles with count=16 each time, and busy low only in REPORT cycles.
REQ-034 Saturation: CNT_W=3, WIN_LEN=16, match=1 constant -> count=7.
REQ-035 Ignore rules: start pulsed at sample 8 of a window, and match=1 in IDLE -> window still ends at sample 16, with IDLE matches not counted.
